// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared WIDTH-bit register.
// Optional macro SHARED_REG_ARBITER_STATS_EN adds per-requester grant counts.
//
// Ports:
//   clk         clock, all state updates on posedge
//   reset       synchronous active-high reset
//   req[N]      request / write-valid per requester
//   lock[N]     keep ownership after the current write
//   wdata[N*W]  write data, requester i at [i*WIDTH +: WIDTH]
//   gnt[N]      registered one-hot grant, zero when idle
//   q[W]        shared register value
//   busy        high while a requester owns the register
//   timeout     one-cycle pulse after a forced release
//   grant_count (STATS_EN only) 8-bit saturating grant count per requester
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               timeout
`ifdef SHARED_REG_ARBITER_STATS_EN
    ,
    output logic [N*8-1:0]     grant_count
`endif
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t            state, state_n;
    logic [N-1:0]      gnt_n;
    logic [WIDTH-1:0]  q_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              timeout_n;

    logic              found;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     own;
    logic              reqo;
    logic              locko;
    logic [WIDTH-1:0]  wsel;
    logic              rel;

    // Rotating search starting just after the last owner.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            idx = (idx == LAST) ? '0 : idx + PW'(1);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Owner's request, lock and data, taken from the one-hot grant.
    always_comb begin
        own   = '0;
        reqo  = 1'b0;
        locko = 1'b0;
        wsel  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                own   = PW'(i);
                reqo  = req[i];
                locko = lock[i];
                wsel  = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rel = !reqo || !locko || (cnt == CMAX);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        q_n       = q;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = OWNED;
                    gnt_n   = {{(N-1){1'b0}}, 1'b1} << sel;
                    cnt_n   = CW'(1);
                end
            end
            OWNED: begin
                if (reqo) begin
                    q_n = wsel;
                end
                if (rel) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    ptr_n     = own;
                    // Forced release only: owner still wanted to keep it.
                    timeout_n = reqo && locko && (cnt == CMAX);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            ptr     <= LAST;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            q       <= q_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

    assign busy = (state == OWNED);

`ifdef SHARED_REG_ARBITER_STATS_EN
    logic [N*8-1:0] gc_n;

    always_comb begin
        gc_n = grant_count;
        if (state == IDLE && found) begin
            for (int i = 0; i < N; i++) begin
                if (sel == PW'(i) && grant_count[i*8 +: 8] != 8'hFF) begin
                    gc_n[i*8 +: 8] = grant_count[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
        end else begin
            grant_count <= gc_n;
        end
    end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: vector table, corner sequences and random
// stimulus against a behavioural model of shared_reg_arbiter.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MH = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    gnt;
    logic [W-1:0]    q;
    logic            busy;
    logic            timeout;
`ifdef SHARED_REG_ARBITER_STATS_EN
    logic [N*8-1:0]  grant_count;
`endif

    shared_reg_arbiter #(
        .N(N),
        .WIDTH(W),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .lock(lock),
        .wdata(wdata),
        .gnt(gnt),
        .q(q),
        .busy(busy),
        .timeout(timeout)
`ifdef SHARED_REG_ARBITER_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: owner index (-1 when nobody owns), last owner,
    // cycles owned so far, register value, timeout pulse, grant counts.
    int   m_own;
    int   m_last;
    int   m_held;
    logic [W-1:0] m_q;
    logic m_to;
    int   m_gc[N];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic [N-1:0] rq,
                         input logic [N-1:0] lk, input logic [N*W-1:0] wd);
        if (r) begin
            m_own  = -1;
            m_last = N - 1;
            m_held = 0;
            m_q    = '0;
            m_to   = 1'b0;
            foreach (m_gc[i]) m_gc[i] = 0;
        end else if (m_own < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_own < 0 && rq[c]) begin
                    m_own  = c;
                    m_held = 1;
                    if (m_gc[c] < 255) m_gc[c]++;
                end
            end
        end else begin
            int o;
            o = m_own;
            m_to = 1'b0;
            if (rq[o]) m_q = wd[o*W +: W];
            if (!rq[o] || !lk[o] || m_held == MH) begin
                m_to   = rq[o] && lk[o] && (m_held == MH);
                m_last = o;
                m_own  = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] lk, input logic [N*W-1:0] wd);
        reset = r;
        req   = rq;
        lock  = lk;
        wdata = wd;
        model(r, rq, lk, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_own < 0) ? '0 : (N'(1) << m_own);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_q"}, 32'(q), 32'(m_q));
        chk({tag, "_busy"}, 32'(busy), 32'(m_own >= 0));
        chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, "_inv"}, 32'($onehot0(gnt) && ((gnt != '0) == busy)), 32'(1));
`ifdef SHARED_REG_ARBITER_STATS_EN
        for (int i = 0; i < N; i++)
            chk({tag, "_gc"}, 32'(grant_count[i*8 +: 8]), 32'(m_gc[i]));
`endif
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic [N-1:0] lk;
        logic [N*W-1:0] wd;
        logic [N-1:0] g;
        logic [W-1:0] qv;
        logic         b;
        logic         t;
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic [3:0] bh;
        logic [3:0] th;
        int runb;
        int nto;
        logic [N-1:0] rq;
        logic [N-1:0] lk;

        // Round robin, burst, then reset mid-burst.
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h1, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'h1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h2, 4'h1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'h2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h4, 4'h2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'h3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h8, 4'h3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'h4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h1, 4'h4, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'h1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'h4, 4'h4, 16'h0500, 4'h4, 4'h1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'h4, 4'h4, 16'h0500, 4'h4, 4'h5, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'h4, 4'h4, 16'h0600, 4'h4, 4'h6, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'h4, 4'h4, 16'h0700, 4'h4, 4'h7, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 4'h0, 16'h0700, 4'h0, 4'h7, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h7, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'h2, 4'h2, 16'h00A0, 4'h2, 4'h7, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'h2, 4'h2, 16'h00A0, 4'h2, 4'hA, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 4'h2, 4'h2, 16'h00A0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 4'h1, 4'h0, 16'h0000, 4'h1, 4'h0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};

        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 22; v++) begin
            tick(tbl[v].rst, tbl[v].rq, tbl[v].lk, tbl[v].wd);
            chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].g));
            chk($sformatf("v%0d_q", v), 32'(q), 32'(tbl[v].qv));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(tbl[v].b));
            chk($sformatf("v%0d_to", v), 32'(timeout), 32'(tbl[v].t));
        end

        // Timeout: requester 1 locked forever.
        tick(1'b1, 4'h0, 4'h0, 16'h0);
        runb = 0;
        nto  = 0;
        for (int c = 0; c < 9; c++) begin
            tick(1'b0, 4'h2, 4'h2, 16'h0030);
            if (busy && gnt == 4'h2) runb++;
            if (timeout) nto++;
            if (c == 8) begin
                chk("to_pulse", 32'(timeout), 32'(1));
                chk("to_idle", 32'(busy), 32'(0));
            end
        end
        chk("to_hold_len", 32'(runb), 32'(8));
        chk("to_count", 32'(nto), 32'(1));
        tick(1'b0, 4'h2, 4'h2, 16'h0030);
        chk("to_regrant", 32'(gnt), 32'(4'h2));
        chk("to_clear", 32'(timeout), 32'(0));
        chk_model("to_seq");

        // Timeout with a competitor: requester 3 wins after the release.
        tick(1'b1, 4'h0, 4'h0, 16'h0);
        for (int c = 0; c < 9; c++) tick(1'b0, 4'h2, 4'h2, 16'h0);
        chk("to2_pulse", 32'(timeout), 32'(1));
        tick(1'b0, 4'hA, 4'h2, 16'h0);
        chk("to2_other", 32'(gnt), 32'(4'h8));

        // Non-owner writes are ignored.
        tick(1'b1, 4'h0, 4'h0, 16'h0);
        tick(1'b0, 4'h1, 4'h1, 16'hF002);
        chk("no_gnt0", 32'(gnt), 32'(4'h1));
        tick(1'b0, 4'h9, 4'h1, 16'hF002);
        chk("no_q2a", 32'(q), 32'(4'h2));
        tick(1'b0, 4'h9, 4'h1, 16'hF002);
        chk("no_q2b", 32'(q), 32'(4'h2));
        tick(1'b0, 4'h8, 4'h1, 16'hF002);
        chk("no_rel", 32'(gnt), 32'(4'h0));
        chk("no_q2c", 32'(q), 32'(4'h2));
        tick(1'b0, 4'h8, 4'h0, 16'hF002);
        chk("no_gnt3", 32'(gnt), 32'(4'h8));
        tick(1'b0, 4'h8, 4'h0, 16'hF002);
        chk("no_qF", 32'(q), 32'(4'hF));
        chk_model("no_seq");

        // Random stimulus against the model.
        tick(1'b1, 4'h0, 4'h0, 16'h0);
        for (int c = 0; c < 2000; c++) begin
            rq = 4'($urandom);
            lk = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            tick(($urandom_range(0, 99) == 0), rq, lk, 16'($urandom));
            chk_model("rnd");
        end

`ifdef SHARED_REG_ARBITER_STATS_EN
        tick(1'b1, 4'h0, 4'h0, 16'h0);
        for (int c = 0; c < 6; c++) tick(1'b0, 4'h4, 4'h0, 16'h0);
        chk("gc2_three", 32'(grant_count[2*8 +: 8]), 32'(3));
        for (int c = 0; c < 600; c++) tick(1'b0, 4'h1, 4'h0, 16'h0);
        chk("gc0_sat", 32'(grant_count[0 +: 8]), 32'(255));
        chk("gc2_keep", 32'(grant_count[2*8 +: 8]), 32'(3));
        chk_model("gc");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
